// File: rtl/dcache_arbiter.sv
// Two-requester data-cache arbiter: requester 0 has priority, requester 1 is
// forced through after STARVE_LIMIT lost arbitrations; one request in flight.
module dcache_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_addr_i,
  input  logic [3:0]  req0_we_i,
  input  logic [31:0] req0_din_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_addr_i,
  input  logic [3:0]  req1_we_i,
  input  logic [31:0] req1_din_i,
  output logic        resp0_valid_o,
  output logic [31:0] resp0_data_o,
  output logic        resp1_valid_o,
  output logic [31:0] resp1_data_o,
  output logic        dcache_req_valid_o,
  input  logic        dcache_req_ready_i,
  output logic [31:0] dcache_addr_o,
  output logic [31:0] dcache_din_o,
  output logic [3:0]  dcache_we_o,
  output logic        dcache_re_o,
  input  logic        dcache_resp_valid_i,
  input  logic [31:0] dcache_dout_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] starve_q;
  logic [31:0]   addr_q;
  logic [31:0]   din_q;
  logic [31:0]   data_q;
  logic [3:0]    we_q;
  logic          winner_q;

  logic        at_limit;
  logic        sel1;
  logic        grant0;
  logic        grant1;
  logic [31:0] resp_word;

  // The reset term keeps the combinational readies at 0 while reset is held.
  assign at_limit  = (starve_q == CW'(STARVE_LIMIT));
  assign sel1      = req1_valid_i && (!req0_valid_i || at_limit);
  assign grant1    = reset_ni && (state_q == IDLE) && sel1;
  assign grant0    = reset_ni && (state_q == IDLE) && req0_valid_i && !sel1;
  assign resp_word = (we_q == 4'b0000) ? dcache_dout_i : 32'h0;

  // NOTE: every state register uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= 32'h0;
      din_q    <= 32'h0;
      data_q   <= 32'h0;
      we_q     <= 4'b0000;
      winner_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            addr_q   <= grant1 ? req1_addr_i : req0_addr_i;
            we_q     <= grant1 ? req1_we_i   : req0_we_i;
            din_q    <= grant1 ? req1_din_i  : req0_din_i;
            winner_q <= grant1;
            state_q  <= ISSUE;
            if (grant1) begin
              starve_q <= '0;
            end else if (req1_valid_i && !at_limit) begin
              starve_q <= starve_q + CW'(1);
            end
          end
        end
        ISSUE: begin
          if (dcache_req_ready_i) begin
            if (dcache_resp_valid_i) begin
              data_q  <= resp_word;
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dcache_resp_valid_i) begin
            data_q  <= resp_word;
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they hold no input-to-output paths
  // apart from the readies.
  assign req0_ready_o       = grant0;
  assign req1_ready_o       = grant1;
  assign dcache_req_valid_o = (state_q == ISSUE);
  assign dcache_addr_o      = addr_q;
  assign dcache_din_o       = din_q;
  assign dcache_we_o        = (state_q == ISSUE) ? we_q : 4'b0000;
  assign dcache_re_o        = (state_q == ISSUE) && (we_q == 4'b0000);
  assign resp0_valid_o      = (state_q == RESP) && !winner_q;
  assign resp1_valid_o      = (state_q == RESP) && winner_q;
  assign resp0_data_o       = resp0_valid_o ? data_q : 32'h0;
  assign resp1_data_o       = resp1_valid_o ? data_q : 32'h0;
  assign busy_o             = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_arbiter.sv
// Self-checking bench for dcache_arbiter: table-driven single transactions,
// starvation ordering, reset abandonment and spurious responses, with a response scoreboard.
module tb_dcache_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_addr, req0_din, req1_addr, req1_din;
  logic [3:0]  req0_we, req1_we;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data;
  logic        dc_req_valid, dc_req_ready, dc_re, dc_resp_valid, busy;
  logic [31:0] dc_addr, dc_din, dc_dout;
  logic [3:0]  dc_we;

  int checks = 0;
  int failures = 0;
  int resp_seen = 0;
  int resp_expected = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dout;
    int          ready_delay;
    int          resp_delay;
    bit          dual;
    logic [31:0] exp_data;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  logic order[10];

  always #5 clk = ~clk;

  dcache_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i              (clk),
    .reset_ni           (rst_n),
    .req0_valid_i       (req0_valid),
    .req0_ready_o       (req0_ready),
    .req0_addr_i        (req0_addr),
    .req0_we_i          (req0_we),
    .req0_din_i         (req0_din),
    .req1_valid_i       (req1_valid),
    .req1_ready_o       (req1_ready),
    .req1_addr_i        (req1_addr),
    .req1_we_i          (req1_we),
    .req1_din_i         (req1_din),
    .resp0_valid_o      (resp0_valid),
    .resp0_data_o       (resp0_data),
    .resp1_valid_o      (resp1_valid),
    .resp1_data_o       (resp1_data),
    .dcache_req_valid_o (dc_req_valid),
    .dcache_req_ready_i (dc_req_ready),
    .dcache_addr_o      (dc_addr),
    .dcache_din_o       (dc_din),
    .dcache_we_o        (dc_we),
    .dcache_re_o        (dc_re),
    .dcache_resp_valid_i(dc_resp_valid),
    .dcache_dout_i      (dc_dout),
    .busy_o             (busy)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb_q.push_back(e);
    resp_expected++;
  endtask

  task automatic drive_req(input logic port, input logic valid, input logic [31:0] addr,
                           input logic [3:0] we, input logic [31:0] din);
    if (port) begin
      req1_valid = valid; req1_addr = addr; req1_we = we; req1_din = din;
    end else begin
      req0_valid = valid; req0_addr = addr; req0_we = we; req0_din = din;
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp0_valid || resp1_valid) begin
      resp_seen++;
      if (sb_q.size() == 0) begin
        check1("resp_unexpected", resp0_valid | resp1_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check1("resp_port1", resp1_valid, e.port);
        check1("resp_port0", resp0_valid, !e.port);
        check32("resp_data", e.port ? resp1_data : resp0_data, e.data);
        check32("resp_other_data", e.port ? resp0_data : resp1_data, 32'h0);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive_req(v.port, 1'b1, v.addr, v.we, v.din);
    dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0;
    #1;
    check1("idle_busy", busy, 1'b0);
    check1("grant_ready", v.port ? req1_ready : req0_ready, 1'b1);
    check1("loser_ready", v.port ? req0_ready : req1_ready, 1'b0);
    push_exp(v.port, v.exp_data);
    @(negedge clk);
    drive_req(v.port, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF);
    for (int i = 0; i <= v.ready_delay; i++) begin
      check1("issue_valid", dc_req_valid, 1'b1);
      check32("issue_addr", dc_addr, v.addr);
      check32("issue_we", {28'h0, dc_we}, {28'h0, v.we});
      check32("issue_din", dc_din, v.din);
      check1("issue_re", dc_re, v.we == 4'b0000);
      check1("issue_busy", busy, 1'b1);
      if (i == v.ready_delay) begin
        dc_req_ready = 1'b1;
        if (v.dual) begin
          dc_resp_valid = 1'b1;
          dc_dout = v.dout;
        end
      end
      @(negedge clk);
    end
    dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0;
    dc_dout = 32'hBAD0_0000 | 32'(idx);
    if (!v.dual) begin
      for (int i = 0; i <= v.resp_delay; i++) begin
        check1("wait_req_valid", dc_req_valid, 1'b0);
        check32("wait_we", {28'h0, dc_we}, 32'h0);
        check1("wait_no_resp", resp0_valid | resp1_valid, 1'b0);
        check1("wait_busy", busy, 1'b1);
        if (i == v.resp_delay) begin
          dc_resp_valid = 1'b1;
          dc_dout = v.dout;
        end
        @(negedge clk);
      end
      dc_resp_valid = 1'b0;
      dc_dout = 32'hBAD0_0000 | 32'(idx);
    end
    check1("resp_latency", v.port ? resp1_valid : resp0_valid, 1'b1);
    check1("resp_busy", busy, 1'b1);
    check1("resp_req_valid", dc_req_valid, 1'b0);
    @(negedge clk);
    check1("resp_one_cycle", resp0_valid | resp1_valid, 1'b0);
    check1("back_idle", busy, 1'b0);
  endtask

  initial begin
    // {port, addr, we, din, dout, ready_delay, resp_delay, dual, expected data}
    vecs[0] = '{1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0, 0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0200, 4'b0011, 32'h0000_1234, 32'hFFFF_0000, 3, 1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_03FC, 4'b1111, 32'hA5A5_A5A5, 32'h0000_55AA, 1, 2, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0044, 4'b0000, 32'h0,         32'hCAFE_F00D, 0, 0, 1'b1, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 32'h0000_0080, 4'b0000, 32'h0,         32'h1234_5678, 2, 0, 1'b1, 32'h1234_5678};
    vecs[5] = '{1'b1, 32'h0000_0ABC, 4'b0000, 32'h0,         32'h0BAD_C0DE, 0, 3, 1'b0, 32'h0BAD_C0DE};
    order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held with every input active: all outputs must read 0.
    rst_n = 1'b0;
    drive_req(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
    drive_req(1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
    dc_req_ready = 1'b1;
    dc_resp_valid = 1'b1;
    dc_dout = 32'h5555_5555;
    #12;
    check1("rst_ready0", req0_ready, 1'b0);
    check1("rst_ready1", req1_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_req_valid", dc_req_valid, 1'b0);
    check32("rst_addr", dc_addr, 32'h0);
    check1("rst_resp", resp0_valid | resp1_valid, 1'b0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Spurious dcache response while idle.
    @(negedge clk);
    dc_resp_valid = 1'b1;
    dc_dout = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      check1("spurious_no_resp", resp0_valid | resp1_valid, 1'b0);
      check1("spurious_idle", busy, 1'b0);
    end
    dc_resp_valid = 1'b0;

    // Reset during WAIT abandons the load; the late response must be ignored.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'h0000_0500, 4'h0, 32'h0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0;
    check1("abort_in_wait", busy, 1'b1);
    drive_req(1'b0, 1'b1, 32'h0000_0600, 4'h0, 32'h0);
    drive_req(1'b1, 1'b1, 32'h0000_0700, 4'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_ready0", req0_ready, 1'b0);
    check1("abort_ready1", req1_ready, 1'b0);
    check1("abort_req_valid", dc_req_valid, 1'b0);
    check32("abort_addr", dc_addr, 32'h0);
    dc_resp_valid = 1'b1;
    dc_dout = 32'h7777_7777;
    @(negedge clk);
    check1("abort_no_resp", resp0_valid | resp1_valid, 1'b0);
    drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    repeat (3) begin
      check1("abort_after_no_resp", resp0_valid | resp1_valid, 1'b0);
      check1("abort_after_idle", busy, 1'b0);
      @(negedge clk);
    end

    // Both requesters continuously valid: starvation forces requester 1 every fifth grant.
    drive_req(1'b0, 1'b1, 32'h0000_1000, 4'h0, 32'h0);
    drive_req(1'b1, 1'b1, 32'h0000_2000, 4'h0, 32'h0);
    #1;
    for (int g = 0; g < 10; g++) begin
      int wait_cyc = 0;
      while (!(req0_ready || req1_ready) && wait_cyc < 8) begin
        @(negedge clk);
        #1;
        wait_cyc++;
      end
      check1("starve_grant1", req1_ready, order[g]);
      check1("starve_grant0", req0_ready, !order[g]);
      push_exp(order[g], 32'h0000_1000 + 32'(g));
      @(negedge clk);
      check32("starve_addr", dc_addr, order[g] ? 32'h0000_2000 : 32'h0000_1000);
      dc_req_ready = 1'b1;
      @(negedge clk);
      dc_req_ready = 1'b0;
      dc_resp_valid = 1'b1;
      dc_dout = 32'h0000_1000 + 32'(g);
      @(negedge clk);
      dc_resp_valid = 1'b0;
      check1("resp_no_grant", req0_ready | req1_ready, 1'b0);
      @(negedge clk);
      #1;
    end
    drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);

    repeat (4) @(negedge clk);
    check32("sb_empty", 32'(sb_q.size()), 32'h0);
    check32("resp_count", 32'(resp_seen), 32'(resp_expected));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
